// File: rtl/sata_oob_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sata_oob_host_ctrl
// Purpose  : Host-side SATA OOB link-initialisation sequencer. Drives the
//            shared burst/primitive transmitter through COMRESET, COMWAKE,
//            D10.2, ALIGN and SYNC, and reports link-up once the device has
//            answered every phase of the handshake.
// Options  : define SATA_OOB_RETRY_LIMIT_EN to enable the retry limit and
//            the FAIL state (otherwise retries are unlimited, o_fail = 0).
// Revision : 1.0 - initial release
// ============================================================================
module sata_oob_host_ctrl #(
  parameter int BURST_CYCLES      = 160,
  parameter int RESET_IDLE_CYCLES = 480,
  parameter int WAKE_IDLE_CYCLES  = 160,
  parameter int N_BURSTS          = 6,
  parameter int COMINIT_TIMEOUT   = 4096,
  parameter int ALIGN_TIMEOUT     = 8192,
  parameter int N_ALIGN_TX        = 4
`ifdef SATA_OOB_RETRY_LIMIT_EN
  ,
  parameter int MAX_RETRIES       = 8
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_cominit_det,
  input  logic       i_comwake_det,
  input  logic       i_align_det,
  input  logic       i_word_ack,
  output logic       o_burst_en,
  output logic [1:0] o_prim_sel,
  output logic       o_link_up,
  output logic       o_busy,
  output logic       o_fail,
  output logic [3:0] o_retry_cnt
);

  // Terminal counts: every counter runs from 0 up to its "last" value.
  localparam logic [15:0] BURST_LAST      = 16'(BURST_CYCLES - 1);
  localparam logic [15:0] RESET_IDLE_LAST = 16'(RESET_IDLE_CYCLES - 1);
  localparam logic [15:0] WAKE_IDLE_LAST  = 16'(WAKE_IDLE_CYCLES - 1);
  localparam logic [15:0] BURSTS_LAST     = 16'(N_BURSTS - 1);
  localparam logic [15:0] CI_TIMEOUT_LAST = 16'(COMINIT_TIMEOUT - 1);
  localparam logic [15:0] AL_TIMEOUT_LAST = 16'(ALIGN_TIMEOUT - 1);
  localparam logic [15:0] ACKS_LAST       = 16'(N_ALIGN_TX - 1);
`ifdef SATA_OOB_RETRY_LIMIT_EN
  localparam logic [3:0]  RETRY_LAST      = 4'(MAX_RETRIES - 1);
`endif

  // Primitive select encoding shared with the serializer.
  localparam logic [1:0] PRIM_ALIGN = 2'd0;
  localparam logic [1:0] PRIM_D10   = 2'd1;
  localparam logic [1:0] PRIM_SYNC  = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_COMRESET     = 4'd1,
    ST_WAIT_COMINIT = 4'd2,
    ST_WAIT_CI_REL  = 4'd3,
    ST_COMWAKE      = 4'd4,
    ST_WAIT_COMWAKE = 4'd5,
    ST_WAIT_CW_REL  = 4'd6,
    ST_SEND_D10     = 4'd7,
    ST_SEND_ALIGN   = 4'd8,
    ST_LINK_UP      = 4'd9,
    ST_FAIL         = 4'd10
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic [15:0] burst_cnt, burst_cnt_nxt;
  logic        in_gap, in_gap_nxt;
  logic [15:0] ack_cnt, ack_cnt_nxt;
  logic [3:0]  retry_cnt, retry_nxt;
  logic [15:0] idle_last;
  logic        do_retry;
  logic        burst_en_nxt;
  logic [1:0]  prim_sel_nxt;
  logic        link_up_nxt;
  logic        busy_nxt;

  // Next-state, counter updates and next registered output values.
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer + 16'd1;
    burst_cnt_nxt = burst_cnt;
    in_gap_nxt    = in_gap;
    ack_cnt_nxt   = ack_cnt;
    retry_nxt     = retry_cnt;
    do_retry      = 1'b0;
    idle_last     = (state == ST_COMWAKE) ? WAKE_IDLE_LAST : RESET_IDLE_LAST;
    burst_en_nxt  = 1'b0;
    prim_sel_nxt  = PRIM_ALIGN;
    link_up_nxt   = 1'b0;
    busy_nxt      = 1'b1;

    case (state)
      ST_IDLE: timer_nxt = '0;
      // Burst/gap pairs; the timer restarts at each phase boundary.
      ST_COMRESET, ST_COMWAKE: begin
        if (!in_gap) begin
          if (timer == BURST_LAST) begin
            in_gap_nxt = 1'b1;
            timer_nxt  = '0;
          end
        end else if (timer == idle_last) begin
          if (burst_cnt == BURSTS_LAST) begin
            state_nxt = (state == ST_COMRESET) ? ST_WAIT_COMINIT : ST_WAIT_COMWAKE;
          end else begin
            burst_cnt_nxt = burst_cnt + 16'd1;
            in_gap_nxt    = 1'b0;
            timer_nxt     = '0;
          end
        end
      end
      // Detection is tested first so it wins over a same-cycle timeout.
      ST_WAIT_COMINIT: begin
        if (i_cominit_det)                   state_nxt = ST_WAIT_CI_REL;
        else if (timer == CI_TIMEOUT_LAST)   do_retry  = 1'b1;
      end
      ST_WAIT_CI_REL: if (!i_cominit_det)    state_nxt = ST_COMWAKE;
      ST_WAIT_COMWAKE: begin
        if (i_comwake_det)                   state_nxt = ST_WAIT_CW_REL;
        else if (timer == CI_TIMEOUT_LAST)   do_retry  = 1'b1;
      end
      ST_WAIT_CW_REL: if (!i_comwake_det)    state_nxt = ST_SEND_D10;
      ST_SEND_D10: begin
        if (i_align_det)                     state_nxt = ST_SEND_ALIGN;
        else if (timer == AL_TIMEOUT_LAST)   do_retry  = 1'b1;
      end
      ST_SEND_ALIGN: begin
        if (i_word_ack) begin
          if (ack_cnt == ACKS_LAST) state_nxt   = ST_LINK_UP;
          else                      ack_cnt_nxt = ack_cnt + 16'd1;
        end
      end
      // Device-initiated reset: re-run the handshake without a retry.
      ST_LINK_UP: if (i_cominit_det)         state_nxt = ST_COMRESET;
      ST_FAIL:    timer_nxt = '0;
      default:    state_nxt = ST_IDLE;
    endcase

    if (do_retry) begin
`ifdef SATA_OOB_RETRY_LIMIT_EN
      if (retry_cnt == RETRY_LAST) begin
        state_nxt = ST_FAIL;
      end else begin
        state_nxt = ST_COMRESET;
        retry_nxt = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
      end
`else
      state_nxt = ST_COMRESET;
      retry_nxt = (retry_cnt == 4'hF) ? retry_cnt : retry_cnt + 4'd1;
`endif
    end

    // A start request overrides every other event.
    if (i_start) begin
      state_nxt = ST_COMRESET;
      retry_nxt = '0;
    end

    // Every state entry (and every restart) begins from clean counters.
    if ((state_nxt != state) || i_start) begin
      timer_nxt     = '0;
      burst_cnt_nxt = '0;
      in_gap_nxt    = 1'b0;
      ack_cnt_nxt   = '0;
    end

    // Outputs follow the state being entered so they appear on the same edge.
    case (state_nxt)
      ST_IDLE, ST_FAIL:        busy_nxt     = 1'b0;
      ST_COMRESET, ST_COMWAKE: burst_en_nxt = !in_gap_nxt;
      ST_SEND_D10: begin
        burst_en_nxt = 1'b1;
        prim_sel_nxt = PRIM_D10;
      end
      ST_SEND_ALIGN:           burst_en_nxt = 1'b1;
      ST_LINK_UP: begin
        burst_en_nxt = 1'b1;
        prim_sel_nxt = PRIM_SYNC;
        link_up_nxt  = 1'b1;
        busy_nxt     = 1'b0;
      end
      default: ;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      timer      <= '0;
      burst_cnt  <= '0;
      in_gap     <= 1'b0;
      ack_cnt    <= '0;
      retry_cnt  <= '0;
      o_burst_en <= 1'b0;
      o_prim_sel <= PRIM_ALIGN;
      o_link_up  <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      burst_cnt  <= burst_cnt_nxt;
      in_gap     <= in_gap_nxt;
      ack_cnt    <= ack_cnt_nxt;
      retry_cnt  <= retry_nxt;
      o_burst_en <= burst_en_nxt;
      o_prim_sel <= prim_sel_nxt;
      o_link_up  <= link_up_nxt;
      o_busy     <= busy_nxt;
    end
  end

  assign o_retry_cnt = retry_cnt;

`ifdef SATA_OOB_RETRY_LIMIT_EN
  // Failure flag registered alongside the other outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) o_fail <= 1'b0;
    else       o_fail <= (state_nxt == ST_FAIL);
  end
`else
  assign o_fail = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sata_oob_host_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sata_oob_host_ctrl
// Purpose  : Self-checking bench for sata_oob_host_ctrl. Expected outputs are
//            queued with the cycle they are due when stimulus is driven and
//            compared on the falling edge of that cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sata_oob_host_ctrl;

    localparam int BURST     = 160;
    localparam int RST_IDLE  = 480;
    localparam int WAKE_IDLE = 160;
    localparam int NB        = 6;
    localparam int CI_TO     = 4096;
    localparam int AL_TO     = 8192;
    localparam int NTX       = 4;
    localparam int RST_SEQ   = NB * (BURST + RST_IDLE);
    localparam int WAKE_SEQ  = NB * (BURST + WAKE_IDLE);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, cominit = 1'b0, comwake = 1'b0, align = 1'b0, ack = 1'b0;
    logic       burst_en, link_up, busy, fail;
    logic [1:0] prim_sel;
    logic [3:0] retry_cnt;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic       burst;
        logic [1:0] prim;
        logic       link;
        logic       busy;
        logic       fail;
        logic [3:0] retry;
    } exp_t;

    typedef struct {
        logic       ack;
        logic       align;
        int         gap;
        logic       burst;
        logic [1:0] prim;
        logic       link;
        logic       busy;
        string      name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[15];

    sata_oob_host_ctrl #(
        .BURST_CYCLES(BURST), .RESET_IDLE_CYCLES(RST_IDLE), .WAKE_IDLE_CYCLES(WAKE_IDLE),
        .N_BURSTS(NB), .COMINIT_TIMEOUT(CI_TO), .ALIGN_TIMEOUT(AL_TO), .N_ALIGN_TX(NTX)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_cominit_det(cominit),
        .i_comwake_det(comwake), .i_align_det(align), .i_word_ack(ack),
        .o_burst_en(burst_en), .o_prim_sel(prim_sel), .o_link_up(link_up),
        .o_busy(busy), .o_fail(fail), .o_retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Queue an expectation, keeping the scoreboard sorted by due cycle.
    task automatic push(input int c, input string nm, input logic b, input logic [1:0] p,
                        input logic l, input logic bz, input logic f, input logic [3:0] r);
        exp_t e;
        int   i;
        e.cyc = c; e.name = nm; e.burst = b; e.prim = p; e.link = l;
        e.busy = bz; e.fail = f; e.retry = r;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    // Expected envelope of one N_BURSTS burst/gap sequence starting at base.
    task automatic push_burst_seq(input int base, input int idle, input logic [3:0] r,
                                  input string nm);
        for (int k = 0; k < NB; k++) begin
            int o;
            o = base + k * (BURST + idle);
            push(o,                    $sformatf("%s_b%0d_rise", nm, k),    1'b1, 2'd0, 1'b0, 1'b1, 1'b0, r);
            push(o + BURST - 1,        $sformatf("%s_b%0d_hi_end", nm, k),  1'b1, 2'd0, 1'b0, 1'b1, 1'b0, r);
            push(o + BURST,            $sformatf("%s_b%0d_gap", nm, k),     1'b0, 2'd0, 1'b0, 1'b1, 1'b0, r);
            push(o + BURST + idle - 1, $sformatf("%s_b%0d_gap_end", nm, k), 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, r);
        end
        push(base + NB * (BURST + idle), {nm, "_wait"}, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, r);
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Start request followed by a responsive device up to the D10.2 phase.
    task automatic to_d10(output int d10_cyc);
        int b;
        start = 1'b1;
        b = cyc + 1;
        push_burst_seq(b, RST_IDLE, 4'd0, "comreset");
        @(negedge clk);
        start = 1'b0;
        tick_to(b + RST_SEQ);
        cominit = 1'b1;
        push(cyc + 1, "wait_ci_release", 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        repeat (3) @(negedge clk);
        cominit = 1'b0;
        b = cyc + 1;
        push_burst_seq(b, WAKE_IDLE, 4'd0, "comwake");
        tick_to(b + WAKE_SEQ);
        comwake = 1'b1;
        push(cyc + 1, "wait_cw_release", 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        repeat (3) @(negedge clk);
        comwake = 1'b0;
        d10_cyc = cyc + 1;
        push(d10_cyc, "d10_entry", 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 4'd0);
        @(negedge clk);
    endtask

    function automatic vec_t mk_vec(input logic a, input logic al, input int g, input logic b,
                                    input logic [1:0] p, input logic l, input logic bz,
                                    input string nm);
        vec_t v;
        v.ack = a; v.align = al; v.gap = g; v.burst = b; v.prim = p;
        v.link = l; v.busy = bz; v.name = nm;
        return v;
    endfunction

    // Scoreboard checker: compares every entry due at this falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (e.cyc != cyc || burst_en !== e.burst || prim_sel !== e.prim || link_up !== e.link ||
                    busy !== e.busy || fail !== e.fail || retry_cnt !== e.retry) begin
                    n_errors++;
                    $display("FAIL %s cyc=%0d due=%0d: got burst=%0b prim=%0d link=%0b busy=%0b fail=%0b retry=%0d, want burst=%0b prim=%0d link=%0b busy=%0b fail=%0b retry=%0d",
                             e.name, cyc, e.cyc, burst_en, prim_sel, link_up, busy, fail, retry_cnt,
                             e.burst, e.prim, e.link, e.busy, e.fail, e.retry);
                end
            end
        end
    end

    initial begin
        int   d10, base, r;
        exp_t e;
`ifdef SATA_OOB_RETRY_LIMIT_EN
        int   per;
`endif
        // D10.2 acks, ALIGN detect, then ALIGN acks up to link-up.
        for (int i = 0; i < 10; i++) vecs[i] = mk_vec(1'b1, 1'b0, 39, 1'b1, 2'd1, 1'b0, 1'b1, "d10_ack");
        vecs[10] = mk_vec(1'b0, 1'b1, 39, 1'b1, 2'd0, 1'b0, 1'b1, "align_det");
        for (int i = 11; i < 14; i++) vecs[i] = mk_vec(1'b1, 1'b0, 39, 1'b1, 2'd0, 1'b0, 1'b1, "align_ack");
        vecs[14] = mk_vec(1'b1, 1'b0, 3, 1'b1, 2'd2, 1'b1, 1'b0, "link_up");

        // Reset state
        repeat (2) @(negedge clk);
        push(cyc + 1, "reset_state", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        push(cyc + 1, "idle_after_reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (3) @(negedge clk);

        // Nominal handshake
        to_d10(d10);
        for (int i = 0; i < 15; i++) begin
            ack   = vecs[i].ack;
            align = vecs[i].align;
            push(cyc + 1, vecs[i].name, vecs[i].burst, vecs[i].prim, vecs[i].link, vecs[i].busy,
                 1'b0, 4'd0);
            @(negedge clk);
            ack   = 1'b0;
            align = 1'b0;
            repeat (vecs[i].gap) @(negedge clk);
        end
        push(cyc + 1, "link_hold", 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        n_checks++;
        if (link_up !== 1'b1 || prim_sel !== 2'd2) begin
            n_errors++;
            $display("FAIL direct_link_hold: link=%0b prim=%0d", link_up, prim_sel);
        end

        // Device COMINIT while linked: restart without a retry, then a silent device
        cominit = 1'b1;
        base = cyc + 1;
        push_burst_seq(base, RST_IDLE, 4'd0, "relink");
        @(negedge clk);
        cominit = 1'b0;
        n_checks++;
        if (link_up !== 1'b0) begin
            n_errors++;
            $display("FAIL direct_link_drop: link=%0b", link_up);
        end
        n_checks++;
        if (retry_cnt !== 4'd0) begin
            n_errors++;
            $display("FAIL direct_relink_retry: retry=%0d", retry_cnt);
        end
        push(base + RST_SEQ + CI_TO - 1, "pre_ci_timeout", 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        r = base + RST_SEQ + CI_TO;
        push(r,                          "ci_timeout_retry", 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'd1);
        push(r + BURST - 1,              "retry_b0_hi_end",  1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'd1);
        push(r + BURST,                  "retry_b0_gap",     1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd1);
        push(r + 2 * (BURST + RST_IDLE), "retry_b2_rise",    1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'd1);

        // Reset in the middle of the third COMRESET burst
        tick_to(r + 2 * (BURST + RST_IDLE) + 20);
        rst = 1'b1;
        push(cyc + 1, "reset_mid_burst", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        n_checks++;
        if (burst_en !== 1'b0 || busy !== 1'b0 || retry_cnt !== 4'd0) begin
            n_errors++;
            $display("FAIL direct_mid_reset: burst=%0b busy=%0b retry=%0d", burst_en, busy, retry_cnt);
        end
        rst = 1'b0;
        push(cyc + 1, "idle_after_mid_reset", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (3) @(negedge clk);

`ifdef SATA_OOB_RETRY_LIMIT_EN
        // Silent device until the retry limit is exhausted
        start = 1'b1;
        base = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        per = RST_SEQ + CI_TO;
        push(base + 7 * per,     "retry7",     1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'd7);
        push(base + 8 * per - 1, "pre_fail",   1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd7);
        push(base + 8 * per,     "fail_state", 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 4'd7);
        tick_to(base + 8 * per + 3);
        start = 1'b1;
        push(cyc + 1, "start_clears_fail", 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        @(negedge clk);
        start = 1'b0;
`else
        // Device never sends ALIGN: D10.2 times out into a retry
        to_d10(d10);
        push(d10 + AL_TO - 1, "d10_before_timeout",  1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 4'd0);
        push(d10 + AL_TO,     "align_timeout_retry", 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'd1);
        push(d10 + AL_TO + 4, "retry_held",          1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'd1);
        tick_to(d10 + AL_TO + 5);
        start = 1'b1;
        push(cyc + 1, "start_clears_retry", 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        @(negedge clk);
        start = 1'b0;
`endif
        repeat (5) @(negedge clk);

        while (sb.size() != 0) begin
            e = sb.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s never compared (due cyc %0d, now %0d)", e.name, e.cyc, cyc);
        end
        if (n_checks < 12) begin
            n_errors++;
            $display("FAIL too few checks: %0d", n_checks);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
